// File: rtl/audio_mixer_pwm_if.sv
// Channel FIFO side of the audio mixer: FWFT data/empty and busy in, pop and done pulses out.
// The master modport is the fill-engine/FIFO side; the mixer uses the slave modport.
interface audio_mixer_pwm_if;
    logic [127:0] fifo_dout;
    logic [3:0]   fifo_empty;
    logic [3:0]   fifo_rd_en;
    logic [3:0]   ch_busy;
    logic [3:0]   ch_done;

    modport master (
        output fifo_dout,
        output fifo_empty,
        output ch_busy,
        input  fifo_rd_en,
        input  ch_done
    );

    modport slave (
        input  fifo_dout,
        input  fifo_empty,
        input  ch_busy,
        output fifo_rd_en,
        output ch_done
    );
endinterface

// File: rtl/audio_mixer_pwm.sv
// Four-channel audio mixer: one stereo pop per busy channel per sample period, EOF detection,
// 2-stage mix pipeline and first-order sigma-delta outputs. AUDIO_MIXER_SATURATE_EN selects
// saturating reduction of the 18-bit sums; otherwise the sums are averaged (>>> 2).
module audio_mixer_pwm #(
    parameter int unsigned CLKS_PER_SAMPLE = 2268,
    parameter logic [31:0] EOF_WORD        = 32'h0011_0045,
    parameter int unsigned EOF_COUNT       = 16
) (
    input  logic                    m00_axi_aclk,
    input  logic                    m00_axi_aresetn,
    audio_mixer_pwm_if.slave        ch_io,
    output logic [15:0]             left_mixer,
    output logic [15:0]             right_mixer,
    output logic                    sample_tick,
    output logic [7:0]              underrun_count,
    output logic                    left_out,
    output logic                    right_out
);
    localparam logic [11:0] LastCnt = 12'(CLKS_PER_SAMPLE - 1);
    localparam logic [4:0]  EofLast = 5'(EOF_COUNT - 1);

    // Sample-rate counter
    logic [11:0] cnt_q, cnt_d;
    logic        tick;

    assign tick  = (cnt_q == LastCnt);
    assign cnt_d = tick ? 12'd0 : cnt_q + 12'd1;

    // Per-channel pop decision in the tick cycle
    logic [31:0] ch_word [4];
    logic [3:0]  pop;
    logic [3:0]  underrun;
    logic [3:0]  is_eof;

    for (genvar n = 0; n < 4; n++) begin : g_ch
        assign ch_word[n]  = ch_io.fifo_dout[32*n +: 32];
        assign pop[n]      = tick & ch_io.ch_busy[n] & ~ch_io.fifo_empty[n];
        assign underrun[n] = tick & ch_io.ch_busy[n] & ch_io.fifo_empty[n];
        assign is_eof[n]   = (ch_word[n] == EOF_WORD);
    end

    assign ch_io.fifo_rd_en = pop;

    // Stage 1: 18-bit signed sums; EOF words, idle and underrun channels contribute 0
    logic signed [17:0] sum_l_d, sum_r_d, sum_l_q, sum_r_q;
    logic               tick1_q;

    always_comb begin
        sum_l_d = '0;
        sum_r_d = '0;
        for (int n = 0; n < 4; n++) begin
            if (pop[n] && !is_eof[n]) begin
                sum_l_d = sum_l_d + {{2{ch_word[n][31]}}, ch_word[n][31:16]};
                sum_r_d = sum_r_d + {{2{ch_word[n][15]}}, ch_word[n][15:0]};
            end
        end
    end

    // EOF run counters and done pulses
    logic [4:0] eof_q [4];
    logic [4:0] eof_d [4];
    logic [3:0] done_d, done_q;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            eof_d[n]  = eof_q[n];
            done_d[n] = 1'b0;
            if (!ch_io.ch_busy[n]) begin
                eof_d[n] = '0;
            end else if (pop[n]) begin
                if (!is_eof[n]) begin
                    eof_d[n] = '0;
                end else if (eof_q[n] == EofLast) begin
                    eof_d[n]  = '0;
                    done_d[n] = 1'b1;
                end else begin
                    eof_d[n] = eof_q[n] + 5'd1;
                end
            end
        end
    end

    assign ch_io.ch_done = done_q;

    // Saturating underrun counter, one increment per starved channel per tick
    logic [7:0] ur_q, ur_d;
    logic [8:0] ur_sum;

    always_comb begin
        ur_sum = {1'b0, ur_q};
        for (int n = 0; n < 4; n++) begin
            ur_sum = ur_sum + 9'(underrun[n]);
        end
        ur_d = ur_sum[8] ? 8'hFF : ur_sum[7:0];
    end

    assign underrun_count = ur_q;

    // Stage 2: reduce the 18-bit sums to 16-bit mixer samples
    logic [15:0] mix_l_d, mix_r_d, mix_l_q, mix_r_q;
    logic        tick2_q;

`ifdef AUDIO_MIXER_SATURATE_EN
    always_comb begin
        if (sum_l_q > 18'sd32767) begin
            mix_l_d = 16'h7FFF;
        end else if (sum_l_q < -18'sd32768) begin
            mix_l_d = 16'h8000;
        end else begin
            mix_l_d = sum_l_q[15:0];
        end
        if (sum_r_q > 18'sd32767) begin
            mix_r_d = 16'h7FFF;
        end else if (sum_r_q < -18'sd32768) begin
            mix_r_d = 16'h8000;
        end else begin
            mix_r_d = sum_r_q[15:0];
        end
    end
`else
    logic unused_sum_lsbs;

    assign mix_l_d         = sum_l_q[17:2];
    assign mix_r_d         = sum_r_q[17:2];
    assign unused_sum_lsbs = ^{sum_l_q[1:0], sum_r_q[1:0]};
`endif

    assign left_mixer  = mix_l_q;
    assign right_mixer = mix_r_q;
    assign sample_tick = tick2_q;

    // Sigma-delta: the carry out of a 16-bit accumulator of offset-binary samples is the bit
    logic [16:0] acc_l_d, acc_l_q, acc_r_d, acc_r_q;
    logic        out_l_q, out_r_q;

    assign acc_l_d = {1'b0, acc_l_q[15:0]} + {1'b0, mix_l_q ^ 16'h8000};
    assign acc_r_d = {1'b0, acc_r_q[15:0]} + {1'b0, mix_r_q ^ 16'h8000};

    assign left_out  = out_l_q;
    assign right_out = out_r_q;

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            cnt_q   <= '0;
            tick1_q <= 1'b0;
            tick2_q <= 1'b0;
            sum_l_q <= '0;
            sum_r_q <= '0;
            mix_l_q <= '0;
            mix_r_q <= '0;
            done_q  <= '0;
            ur_q    <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            out_l_q <= 1'b0;
            out_r_q <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                eof_q[n] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            tick1_q <= tick;
            tick2_q <= tick1_q;
            if (tick) begin
                sum_l_q <= sum_l_d;
                sum_r_q <= sum_r_d;
            end
            if (tick1_q) begin
                mix_l_q <= mix_l_d;
                mix_r_q <= mix_r_d;
            end
            done_q  <= done_d;
            ur_q    <= ur_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            out_l_q <= acc_l_q[16];
            out_r_q <= acc_r_q[16];
            for (int n = 0; n < 4; n++) begin
                eof_q[n] <= eof_d[n];
            end
        end
    end

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// Bench for audio_mixer_pwm: queue-backed FWFT FIFOs, an arithmetic mix/EOF/underrun model,
// directed scenarios and a randomized phase. Short sample period keeps the run small.
module tb_audio_mixer_pwm;
    localparam int unsigned CPS  = 20;
    localparam logic [31:0] EOFW = 32'h0011_0045;
    localparam int          EOFN = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    audio_mixer_pwm_if bus ();

    logic [15:0] left_mixer, right_mixer;
    logic        sample_tick, left_out, right_out;
    logic [7:0]  underrun_count;

    audio_mixer_pwm #(
        .CLKS_PER_SAMPLE (CPS),
        .EOF_WORD        (EOFW),
        .EOF_COUNT       (EOFN)
    ) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .ch_io           (bus.slave),
        .left_mixer      (left_mixer),
        .right_mixer     (right_mixer),
        .sample_tick     (sample_tick),
        .underrun_count  (underrun_count),
        .left_out        (left_out),
        .right_out       (right_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference reduction of a mixed sum, from plain integer arithmetic
    function automatic logic [15:0] reduce(input int s);
`ifdef AUDIO_MIXER_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
`else
        return 16'(s >>> 2);
`endif
    endfunction

    // FIFO contents per channel; front is what the FWFT port shows
    logic [31:0] fq [4][$];
    logic [3:0]  rd_seen = '0;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int n = 0; n < 4; n++) begin
                if (rd_seen[n] && fq[n].size() > 0) void'(fq[n].pop_front());
            end
        end
        #2;
        for (int n = 0; n < 4; n++) begin
            if (fq[n].size() > 0) begin
                bus.fifo_dout[32*n +: 32] = fq[n][0];
                bus.fifo_empty[n]         = 1'b0;
            end else begin
                bus.fifo_dout[32*n +: 32] = $urandom;
                bus.fifo_empty[n]         = 1'b1;
            end
        end
    end

    // Model state: sample phase, pending mixer results, EOF runs, underruns
    typedef struct {
        int          due;
        logic [15:0] l;
        logic [15:0] r;
    } samp_t;

    samp_t       pend [$];
    int          phase = 0;
    int          gcyc = 0;
    int          ur_m = 0;
    int          eofc [4];
    int          done_seen0 = 0;
    logic [3:0]  done_exp = '0;
    logic [15:0] mix_l_m = '0;
    logic [15:0] mix_r_m = '0;

    always @(negedge clk) begin : mon
        logic [3:0]  exp_rd;
        logic [3:0]  done_nxt;
        logic [31:0] w;
        int          sl, sr;
        samp_t       s;
        if (!rst_n) begin
            phase = 0;
            gcyc = 0;
            ur_m = 0;
            for (int n = 0; n < 4; n++) eofc[n] = 0;
            done_exp = '0;
            mix_l_m = '0;
            mix_r_m = '0;
            pend.delete();
            rd_seen = '0;
            check("rst_rd_en", bus.fifo_rd_en, 0);
            check("rst_done", bus.ch_done, 0);
            check("rst_tick", sample_tick, 0);
            check("rst_mix", {left_mixer, right_mixer}, 0);
            check("rst_underrun", underrun_count, 0);
            check("rst_pdm", {left_out, right_out}, 0);
        end else begin
            exp_rd = '0;
            done_nxt = '0;
            check("underrun", underrun_count, ur_m);
            check("ch_done", bus.ch_done, done_exp);
            if (bus.ch_done[0]) done_seen0++;
            if (phase == CPS - 1) begin
                sl = 0;
                sr = 0;
                for (int n = 0; n < 4; n++) begin
                    if (bus.ch_busy[n]) begin
                        if (fq[n].size() > 0) begin
                            exp_rd[n] = 1'b1;
                            w = fq[n][0];
                            if (w == EOFW) begin
                                eofc[n]++;
                                if (eofc[n] == EOFN) begin
                                    done_nxt[n] = 1'b1;
                                    eofc[n] = 0;
                                end
                            end else begin
                                eofc[n] = 0;
                                sl += int'($signed(w[31:16]));
                                sr += int'($signed(w[15:0]));
                            end
                        end else begin
                            ur_m = (ur_m < 255) ? ur_m + 1 : 255;
                        end
                    end
                end
                s.due = gcyc + 2;
                s.l = reduce(sl);
                s.r = reduce(sr);
                pend.push_back(s);
            end
            check("rd_en", bus.fifo_rd_en, exp_rd);
            for (int n = 0; n < 4; n++) begin
                if (!bus.ch_busy[n]) eofc[n] = 0;
            end
            done_exp = done_nxt;
            if (pend.size() > 0 && pend[0].due == gcyc) begin
                check("sample_tick", sample_tick, 1);
                mix_l_m = pend[0].l;
                mix_r_m = pend[0].r;
                void'(pend.pop_front());
            end else begin
                check("sample_tick", sample_tick, 0);
            end
            check("left_mixer", left_mixer, mix_l_m);
            check("right_mixer", right_mixer, mix_r_m);
            rd_seen = bus.fifo_rd_en;
            gcyc++;
            phase = (phase + 1) % CPS;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.ch_busy = '0;
        for (int n = 0; n < 4; n++) fq[n].delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    // Returns the index of the negedge (0 = first after the call) where a pop shows up
    task automatic wait_rd(output int c);
        c = 0;
        @(negedge clk);
        while (bus.fifo_rd_en == 4'h0 && c < 4 * CPS) begin
            c++;
            @(negedge clk);
        end
        check("wait_rd_bound", {31'd0, bus.fifo_rd_en != 4'h0}, 1);
    endtask

    task automatic push_all(input logic [31:0] w, input int k);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < k; i++) fq[n].push_back(w);
        end
    endtask

    task automatic duty(input string tag, input int exp_ones, input bit alt);
        int ol, orr, tr;
        logic prev;
        ol = 0;
        orr = 0;
        tr = 0;
        @(negedge clk);
        prev = left_out;
        repeat (64) begin
            @(negedge clk);
            ol += int'(left_out);
            orr += int'(right_out);
            if (left_out != prev) tr++;
            prev = left_out;
        end
        check({tag, "_ones_l"}, ol, exp_ones);
        check({tag, "_ones_r"}, orr, exp_ones);
        if (alt) check({tag, "_toggles"}, tr, 64);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c, d0;
        logic        rd_any;
        logic [15:0] e_a, e_pos, e_neg;
        logic [31:0] w4000;
`ifdef AUDIO_MIXER_SATURATE_EN
        e_a = 16'h0404; e_pos = 16'h7FFF; e_neg = 16'h8000; w4000 = 32'h1000_1000;
`else
        e_a = 16'h0101; e_pos = 16'h7000; e_neg = 16'h9000; w4000 = 32'h4000_4000;
`endif
        bus.ch_busy = '0;
        do_reset();

        // First tick timing and basic mix
        bus.ch_busy = 4'hF;
        push_all(32'h0101_0101, 1);
        wait_rd(c);
        check("first_tick_cycle", c, CPS - 1);
        check("first_rd_en", bus.fifo_rd_en, 4'hF);
        @(negedge clk);
        check("rd_en_pulse", bus.fifo_rd_en, 0);
        check("no_early_tick", sample_tick, 0);
        @(negedge clk);
        check("tick_latency", sample_tick, 1);
        check("mix_a_l", left_mixer, e_a);
        check("mix_a_r", right_mixer, e_a);

        // Full-scale positive and negative
        push_all(32'h7000_7000, 1);
        wait_rd(c);
        repeat (2) @(negedge clk);
        check("mix_pos", left_mixer, e_pos);
        push_all(32'h9000_9000, 1);
        wait_rd(c);
        repeat (2) @(negedge clk);
        check("mix_neg", right_mixer, e_neg);

        // EOF run broken by one data word, then a full run
        do_reset();
        bus.ch_busy = 4'h1;
        for (int i = 0; i < 15; i++) fq[0].push_back(EOFW);
        fq[0].push_back(32'h0001_0001);
        for (int i = 0; i < 16; i++) fq[0].push_back(EOFW);
        d0 = done_seen0;
        for (int i = 1; i <= 32; i++) begin
            wait_rd(c);
            if (i == 15 || i == 31) check("eof_no_done_early", done_seen0 - d0, 0);
        end
        @(negedge clk);
        check("eof_done_pulse", bus.ch_done, 4'h1);
        repeat (3 * CPS) @(negedge clk);
        check("eof_done_once", done_seen0 - d0, 1);
        bus.ch_busy = '0;

        // Underrun counting and saturation
        do_reset();
        bus.ch_busy = 4'h4;
        rd_any = 1'b0;
        repeat (3 * CPS + 1) begin
            @(negedge clk);
            rd_any |= bus.fifo_rd_en[2];
        end
        check("underrun_no_rd", rd_any, 0);
        check("underrun_3", underrun_count, 3);
        repeat (300 * CPS) @(negedge clk);
        check("underrun_sat", underrun_count, 255);

        // Sigma-delta density: idle is exactly 50%, 0x4000 is 3 of 4
        do_reset();
        repeat (3) @(negedge clk);
        duty("pdm_idle", 32, 1'b1);
        bus.ch_busy = 4'hF;
        push_all(w4000, 12);
        wait_rd(c);
        repeat (4) @(negedge clk);
        check("mix_4000", left_mixer, 16'h4000);
        duty("pdm_4000", 48, 1'b0);

        // Reset one cycle after a tick
        do_reset();
        bus.ch_busy = 4'hF;
        push_all(32'h1234_5678, 1);
        wait_rd(c);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tick", sample_tick, 0);
        check("midrst_mix", {left_mixer, right_mixer}, 0);
        check("midrst_rd", bus.fifo_rd_en, 0);
        check("midrst_pdm", {left_out, right_out}, 0);
        for (int n = 0; n < 4; n++) fq[n].delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        fq[1].push_back(32'hF000_0800);
        wait_rd(c);
        check("midrst_next_tick", c, CPS - 1);
        repeat (3) @(negedge clk);

        // Randomized traffic against the model
        do_reset();
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #2;
            bus.ch_busy = 4'($urandom);
            for (int n = 0; n < 4; n++) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    fq[n].push_back(($urandom_range(0, 3) == 0) ? EOFW : 32'($urandom));
                end
            end
            repeat (CPS - 1) @(posedge clk);
        end
        repeat (2 * CPS) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_mixer_pwm.md
Name: audio_mixer_pwm

Overview:
Downstream consumer of the four audio channel FIFOs that the AXI4 fbreader fill engine loads from DDR. Pops one 32-bit stereo word per active channel at 44.1 kHz and detects the end-of-sound marker per channel. Mixes the four channels into signed 16-bit left/right samples and drives 1-bit first-order sigma-delta outputs to the board's audio filter pins (left_out/right_out).

Parameters:
CLKS_PER_SAMPLE, 2268, m00_axi_aclk cycles per audio sample (100 MHz / 44.1 kHz); legal range 4..4095
EOF_WORD, 32'h00110045, 32-bit end-of-sound marker word
EOF_COUNT, 16, consecutive EOF_WORD pops that end a sound; legal range 1..31

Ports:
m00_axi_aclk  in  1  system clock
m00_axi_aresetn  in  1  asynchronous active-low reset
fifo_dout  in  128  channel FIFO first-word-fall-through data; ch n = [32n+31:32n]; word[31:16] = left, word[15:0] = right, signed
fifo_empty  in  4  per-channel FIFO empty
fifo_rd_en  out  4  per-channel pop, 1-cycle pulse
ch_busy  in  4  channel is assigned a sound (from fill engine)
ch_done  out  4  1-cycle pulse: channel reached EOF
left_mixer  out  16  mixed left sample, signed
right_mixer  out  16  mixed right sample, signed
sample_tick  out  1  1-cycle pulse when left_mixer/right_mixer update
underrun_count  out  8  saturating count of busy-but-empty pops
left_out  out  1  sigma-delta left bitstream
right_out  out  1  sigma-delta right bitstream

Behaviour:
- Reset (async, any time incl. mid-sample): all outputs 0; counter_44k1 = 0; EOF counters 0; sigma-delta accumulators 0; pipeline flushed.
- counter_44k1 (12 bit) counts 0..CLKS_PER_SAMPLE-1 and wraps; internal tick is high in the cycle where counter == CLKS_PER_SAMPLE-1.
- Tick cycle T, per channel n:
  - ch_busy[n] & !fifo_empty[n]: fifo_rd_en[n]=1 in T; word captured from fifo_dout in T.
  - ch_busy[n] & fifo_empty[n]: no pop; sample = 0; underrun_count += 1 (saturates at 255; once per channel per tick).
  - !ch_busy[n]: no pop; sample = 0.
- EOF handling: a popped word == EOF_WORD contributes 0 and increments eof_cnt[n]; any other popped word clears eof_cnt[n].
  - When eof_cnt[n] reaches EOF_COUNT, ch_done[n] pulses in T+1 and eof_cnt[n] clears.
  - eof_cnt[n] clears whenever ch_busy[n]=0.
  - Done is still issued if busy falls in T+1, because busy was sampled at T.
- Pipeline:
  - T+1: 18-bit signed sums of the 4 left and 4 right samples registered.
  - T+2: reduction (see Optional Feature) registered into left_mixer/right_mixer; sample_tick=1 in T+2.
  - Total latency tick → output: 2 cycles.
- Sigma-delta, every cycle: acc_l (17 bit) <= {1'b0, acc_l[15:0]} + (left_mixer ^ 16'h8000); left_out <= acc_l carry (bit16) registered. Right is identical.
  - Outputs the offset-binary density: 0x0000 → 50% duty, 0x7FFF → ~100%, 0x8000 → 0%.
- No other handshake; rd_en is never asserted for an empty FIFO nor more than once per tick.

Optional Feature:
Macro AUDIO_MIXER_SATURATE_EN.
- Defined: reduction = saturate 18-bit sum to 16 bits (>32767 → 16'h7FFF, <-32768 → 16'h8000), full-scale sum preserved.
- Undefined: reduction = arithmetic shift right by 2 of the 18-bit sum (average, never clips), bits [17:2].

Test Plan:
- Reset, ch_busy=4'hF, all FIFOs hold 32'h01010101 → first tick at cycle 2267 after reset release; fifo_rd_en=4'hF for 1 cycle; 2 cycles later sample_tick=1. With SATURATE_EN: left_mixer=right_mixer=16'h0404. Without: 16'h0101.
- Four channels 32'h70007000 (SATURATE_EN) → mixer 16'h7FFF. Four channels 32'h90009000 → 16'h8000. Without macro: 16'h7000 and 16'h9000.
- ch 0 busy, its FIFO delivers 15 × EOF_WORD then 32'h00010001 then 16 × EOF_WORD → no done after the first 15; ch_done[0] pulses exactly once, 1 cycle after the 32nd tick; EOF words mix as 0.
- ch 2 busy with empty FIFO for 3 ticks → fifo_rd_en[2] never high, underrun_count=3; 300 ticks → stays at 255.
- All channels idle (mixer 0) → left_out duty exactly 50% (alternating 0/1). Mixer 16'h4000 → 3 of every 4 cycles high.
- Assert reset mid-pipeline, one cycle after a tick → sample_tick never pulses, all outputs 0 immediately; next tick occurs CLKS_PER_SAMPLE cycles after release.
